// File: rtl/proc_pkg.sv
// Shared types and instruction-field positions for the multi-cycle processor.
// Imported by the core and its register file.
package proc_pkg;

   typedef enum logic [3:0] {
      OP_NOOP  = 4'd0,
      OP_STORE = 4'd1,
      OP_LOAD  = 4'd2,
      OP_ADD   = 4'd3,
      OP_SUB   = 4'd4,
      OP_HALT  = 4'd5,
      OP_LDI   = 4'd6,
      OP_BRZ   = 4'd7
   } opcode_t;

   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_NOOP   = 4'd3,
      S_LOAD_A = 4'd4,
      S_LOAD_B = 4'd5,
      S_STORE  = 4'd6,
      S_ADD    = 4'd7,
      S_SUB    = 4'd8,
      S_HALT   = 4'd9,
      S_LDI    = 4'd10,
      S_BRZ    = 4'd11
   } state_t;

   typedef enum logic [1:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_PASS_A,
      ALU_ZERO
   } alu_op_t;

   localparam int OP_MSB    = 15;
   localparam int OP_LSB    = 12;
   localparam int RA_MSB    = 11;
   localparam int RA_LSB    = 8;
   localparam int RB_MSB    = 7;
   localparam int RB_LSB    = 4;
   localparam int RD_MSB    = 3;
   localparam int RD_LSB    = 0;
   localparam int IMM_MSB   = 11;
   localparam int IMM_LSB   = 4;
   localparam int SADDR_MSB = 7;
   localparam int SADDR_LSB = 0;
   localparam int LADDR_MSB = 11;
   localparam int LADDR_LSB = 4;

   function automatic opcode_t ir_opcode(input logic [15:0] ir);
      return opcode_t'(ir[OP_MSB:OP_LSB]);
   endfunction

   // Unassigned opcodes 8..15 fall through to the NOOP state.
   function automatic state_t dispatch(input opcode_t op);
      state_t s;
      case (op)
         OP_STORE: s = S_STORE;
         OP_LOAD:  s = S_LOAD_A;
         OP_ADD:   s = S_ADD;
         OP_SUB:   s = S_SUB;
         OP_HALT:  s = S_HALT;
         OP_LDI:   s = S_LDI;
         OP_BRZ:   s = S_BRZ;
         default:  s = S_NOOP;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/proc_regfile.sv
// 16 x DW register file: two combinational read ports, one synchronous write port.
// A write in cycle n is visible on the read ports in cycle n+1.
module proc_regfile
   import proc_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          Reset,
   input  logic [3:0]    ra_addr,
   input  logic [3:0]    rb_addr,
   output logic [DW-1:0] ra_data,
   output logic [DW-1:0] rb_data,
   input  logic          we,
   input  logic [3:0]    wr_addr,
   input  logic [DW-1:0] wr_data
);

   logic [DW-1:0] regs_q [16];
   logic [DW-1:0] regs_d [16];

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      regs_d = regs_q;
      if (we) begin
         regs_d[wr_addr] = wr_data;
      end
   end

   // NOTE: the array is built from flops, not a RAM macro, so a full asynchronous clear is legal here.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         regs_q <= '{default: '0};
      end else begin
         // NOTE: non-blocking assignment keeps every flop updating from pre-edge values.
         regs_q <= regs_d;
      end
   end

   assign ra_data = regs_q[ra_addr];
   assign rb_data = regs_q[rb_addr];

endmodule

// File: rtl/multicycle_processor.sv
// Multi-cycle 16-bit-instruction core: FSM control, PC/IR, ALU and register file,
// with req/ack handshakes to external instruction and data memories.
module multicycle_processor
   import proc_pkg::*;
#(
   parameter int DW   = 16,
   parameter int PC_W = 7
) (
   input  logic            clk,
   input  logic            Reset,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic [15:0]     imem_rdata,
   input  logic            imem_ack,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [7:0]      dmem_addr,
   output logic [DW-1:0]   dmem_wdata,
   input  logic [DW-1:0]   dmem_rdata,
   input  logic            dmem_ack,
   output logic            halted,
   output logic [15:0]     IR_Out,
   output logic [PC_W-1:0] PC_Out,
   output logic [3:0]      State,
   output logic [3:0]      NextState,
   output logic [DW-1:0]   ALU_A,
   output logic [DW-1:0]   ALU_B,
   output logic [DW-1:0]   ALU_Out
);

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     ir_q, ir_d;
   logic [DW-1:0]   ld_q, ld_d;

   opcode_t         op;
   alu_op_t         alu_op;
   logic [DW-1:0]   alu_a, alu_b, alu_out;
   logic            rf_we;
   logic [3:0]      rf_waddr;
   logic [DW-1:0]   rf_wdata;

   assign op = ir_opcode(ir_q);

   proc_regfile #(.DW(DW)) u_regfile (
      .clk     (clk),
      .Reset   (Reset),
      .ra_addr (ir_q[RA_MSB:RA_LSB]),
      .rb_addr (ir_q[RB_MSB:RB_LSB]),
      .ra_data (alu_a),
      .rb_data (alu_b),
      .we      (rf_we),
      .wr_addr (rf_waddr),
      .wr_data (rf_wdata)
   );

   always_comb begin
      alu_op = ALU_ZERO;
      case (state_q)
         S_ADD:         alu_op = ALU_ADD;
         S_SUB:         alu_op = ALU_SUB;
         S_STORE, S_BRZ: alu_op = ALU_PASS_A;
         default:       alu_op = ALU_ZERO;
      endcase
   end

   always_comb begin
      alu_out = '0;
      case (alu_op)
         ALU_ADD:    alu_out = alu_a + alu_b;
         ALU_SUB:    alu_out = alu_a - alu_b;
         ALU_PASS_A: alu_out = alu_a;
         default:    alu_out = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      ld_d     = ld_q;
      rf_we    = 1'b0;
      rf_waddr = ir_q[RD_MSB:RD_LSB];
      rf_wdata = alu_out;
      case (state_q)
         S_INIT: state_d = S_FETCH;
         S_FETCH: begin
            if (imem_ack) begin
               ir_d    = imem_rdata;
               pc_d    = pc_q + PC_W'(1);
               state_d = S_DECODE;
            end
         end
         S_DECODE: state_d = dispatch(op);
         S_NOOP:   state_d = S_FETCH;
         S_LOAD_A: begin
            if (dmem_ack) begin
               ld_d    = dmem_rdata;
               state_d = S_LOAD_B;
            end
         end
         S_LOAD_B: begin
            rf_we    = 1'b1;
            rf_wdata = ld_q;
            state_d  = S_FETCH;
         end
         S_STORE: begin
            if (dmem_ack) begin
               state_d = S_FETCH;
            end
         end
         S_ADD, S_SUB: begin
            rf_we   = 1'b1;
            state_d = S_FETCH;
         end
         S_LDI: begin
            rf_we    = 1'b1;
            rf_wdata = DW'(ir_q[IMM_MSB:IMM_LSB]);
            state_d  = S_FETCH;
         end
         S_BRZ: begin
            if (alu_a == '0) begin
               pc_d = ir_q[PC_W-1:0];
            end
            state_d = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_q <= S_INIT;
         pc_q    <= '0;
         ir_q    <= '0;
         ld_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         ld_q    <= ld_d;
      end
   end

   // Bus strobes decode straight from state_q so an asynchronous reset drops them at once.
   always_comb begin
      imem_req   = (state_q == S_FETCH);
      dmem_req   = (state_q == S_LOAD_A) || (state_q == S_STORE);
      dmem_we    = (state_q == S_STORE);
      halted     = (state_q == S_HALT);
      dmem_addr  = '0;
      dmem_wdata = '0;
      if (state_q == S_STORE) begin
         dmem_addr  = ir_q[SADDR_MSB:SADDR_LSB];
         dmem_wdata = alu_a;
      end else if (state_q == S_LOAD_A) begin
         dmem_addr  = ir_q[LADDR_MSB:LADDR_LSB];
      end
   end

   assign imem_addr = pc_q;
   assign IR_Out    = ir_q;
   assign PC_Out    = pc_q;
   assign State     = state_q;
   assign NextState = state_d;
   assign ALU_A     = alu_a;
   assign ALU_B     = alu_b;
   assign ALU_Out   = alu_out;

endmodule

// File: tb/tb_multicycle_processor.sv
// Bench for multicycle_processor: instruction-level reference model plus
// wait-state memory responders, directed programs and randomized programs.
module tb_multicycle_processor;

   localparam int DW   = 16;
   localparam int PC_W = 7;

   logic            clk = 1'b0;
   logic            Reset = 1'b1;
   logic            imem_req, imem_ack;
   logic [PC_W-1:0] imem_addr;
   logic [15:0]     imem_rdata;
   logic            dmem_req, dmem_we, dmem_ack;
   logic [7:0]      dmem_addr;
   logic [DW-1:0]   dmem_wdata, dmem_rdata;
   logic            halted;
   logic [15:0]     IR_Out;
   logic [PC_W-1:0] PC_Out;
   logic [3:0]      State, NextState;
   logic [DW-1:0]   ALU_A, ALU_B, ALU_Out;

   always #5 clk = ~clk;

   multicycle_processor #(.DW(DW), .PC_W(PC_W)) dut (
      .clk        (clk),
      .Reset      (Reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .imem_ack   (imem_ack),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_rdata (dmem_rdata),
      .dmem_ack   (dmem_ack),
      .halted     (halted),
      .IR_Out     (IR_Out),
      .PC_Out     (PC_Out),
      .State      (State),
      .NextState  (NextState),
      .ALU_A      (ALU_A),
      .ALU_B      (ALU_B),
      .ALU_Out    (ALU_Out)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Memories and wait-state control
   logic [15:0]   imem   [2**PC_W];
   logic [DW-1:0] dmem   [256];
   logic [DW-1:0] wr_mem [256];
   int            wr_count, last_wr_addr;
   logic [DW-1:0] last_wr_data;
   int            iwait_max = 0, dwait_max = 0;
   bit            rand_waits = 1'b0;
   bit            i_act, d_act;
   int            i_cnt, i_lim, d_cnt, d_lim;

   // Instruction-level reference model
   logic [DW-1:0]   m_regs [16];
   logic [PC_W-1:0] m_pc;
   logic [DW-1:0]   pre_a, pre_b, exp_wdata, sub_seen;
   logic [15:0]     cur_ins;
   logic [7:0]      exp_addr;
   bit              exp_we, after_fetch, have_prev, d_granted;
   int              cur_op, phase, d_post, stalls, cyc, last_grant;
   int              fa_q [$];

   function automatic int exec_state(input int op);
      case (op)
         1:       return 6;
         2:       return 4;
         3:       return 7;
         4:       return 8;
         5:       return 9;
         6:       return 10;
         7:       return 11;
         default: return 3;
      endcase
   endfunction

   function automatic int pick(input int mx);
      return rand_waits ? int'($urandom_range(0, mx)) : mx;
   endfunction

   task automatic model_reset();
      foreach (m_regs[i]) m_regs[i] = '0;
      m_pc        = '0;
      after_fetch = 1'b0;
      have_prev   = 1'b0;
      d_granted   = 1'b0;
      stalls      = 0;
      phase       = 0;
      d_post      = 0;
      cur_op      = 0;
      fa_q.delete();
   endtask

   // Executes the whole instruction at the moment its fetch is acknowledged.
   task automatic fetch_grant();
      logic [15:0] ins;
      int          op;
      if (have_prev) check("latency", cyc - last_grant, 3 + ((cur_op == 2) ? 1 : 0) + stalls);
      have_prev  = 1'b1;
      last_grant = cyc;
      stalls     = 0;
      fa_q.push_back(int'(imem_addr));
      ins     = imem[m_pc];
      op      = int'(ins[15:12]);
      cur_ins = ins;
      pre_a   = m_regs[ins[11:8]];
      pre_b   = m_regs[ins[7:4]];
      m_pc    = m_pc + PC_W'(1);
      case (op)
         1: begin
            exp_we = 1'b1; exp_addr = ins[7:0]; exp_wdata = pre_a;
            dmem[ins[7:0]] = pre_a;
         end
         2: begin
            exp_we = 1'b0; exp_addr = ins[11:4];
            m_regs[ins[3:0]] = dmem[ins[11:4]];
         end
         3: m_regs[ins[3:0]] = pre_a + pre_b;
         4: m_regs[ins[3:0]] = pre_a - pre_b;
         6: m_regs[ins[3:0]] = DW'(ins[11:4]);
         7: if (pre_a == '0) m_pc = ins[PC_W-1:0];
         default: ;
      endcase
      cur_op      = op;
      after_fetch = 1'b1;
      phase       = 0;
      d_granted   = 1'b0;
      d_post      = 0;
   endtask

   // Compare process and memory responders, all on the falling edge.
   always @(negedge clk) begin
      int            es;
      bit            exp_halt;
      logic [DW-1:0] ea;
      if (Reset) begin
         model_reset();
         imem_ack = 1'b0;
         dmem_ack = 1'b0;
         i_act    = 1'b0;
         d_act    = 1'b0;
      end else begin
         cyc++;
         exp_halt = after_fetch && (cur_op == 5) && (phase >= 1);
         check("halted", halted, exp_halt);
         if (exp_halt) begin
            check("halt_state", State, 9);
            check("halt_next", NextState, 9);
            check("halt_ireq", imem_req, 0);
            check("halt_dreq", dmem_req, 0);
            check("halt_pc", PC_Out, m_pc);
         end else if (imem_req) begin
            check("fetch_state", State, 1);
            check("fetch_addr", imem_addr, m_pc);
            check("fetch_pc", PC_Out, m_pc);
            check("fetch_dreq", dmem_req, 0);
            check("fetch_alu", ALU_Out, 0);
         end else if (after_fetch) begin
            if (phase == 0)       es = 2;
            else if (cur_op == 1) es = d_granted ? 1 : 6;
            else if (cur_op == 2) es = !d_granted ? 4 : ((d_post == 0) ? 5 : 1);
            else                  es = (phase == 1) ? exec_state(cur_op) : 1;
            check("state", State, es);
            check("ir", IR_Out, cur_ins);
            check("alu_a", ALU_A, pre_a);
            check("alu_b", ALU_B, pre_b);
            if (es == 2) check("next_decode", NextState, exec_state(cur_op));
            else if (es inside {3, 5, 7, 8, 10, 11}) check("next_fetch", NextState, 1);
            case (es)
               7:       ea = pre_a + pre_b;
               8:       ea = pre_a - pre_b;
               6, 11:   ea = pre_a;
               default: ea = '0;
            endcase
            check("alu_out", ALU_Out, ea);
            check("dmem_req", dmem_req, (es == 4) || (es == 6));
            if (dmem_req) begin
               check("dmem_we", dmem_we, exp_we);
               check("dmem_addr", dmem_addr, exp_addr);
               if (exp_we) check("dmem_wdata", dmem_wdata, exp_wdata);
            end
            if (es == 8) sub_seen = ALU_Out;
            phase++;
            if (d_granted) d_post++;
         end else begin
            check("init_state", State, 0);
            check("init_dreq", dmem_req, 0);
         end

         imem_ack = 1'b0;
         if (imem_req) begin
            if (!i_act) begin i_act = 1'b1; i_cnt = 0; i_lim = pick(iwait_max); end
            if (i_cnt >= i_lim) begin
               imem_ack   = 1'b1;
               imem_rdata = imem[imem_addr];
               fetch_grant();
            end else begin
               i_cnt++;
               stalls++;
            end
         end else begin
            i_act = 1'b0;
         end

         dmem_ack = 1'b0;
         if (dmem_req) begin
            if (!d_act) begin d_act = 1'b1; d_cnt = 0; d_lim = pick(dwait_max); end
            if (d_cnt >= d_lim) begin
               dmem_ack  = 1'b1;
               d_granted = 1'b1;
               d_post    = 0;
               if (dmem_we) begin
                  wr_count++;
                  wr_mem[dmem_addr] = dmem_wdata;
                  last_wr_addr = int'(dmem_addr);
                  last_wr_data = dmem_wdata;
               end else begin
                  dmem_rdata = dmem[dmem_addr];
               end
            end else begin
               d_cnt++;
               stalls++;
            end
         end else begin
            d_act = 1'b0;
         end
      end
   end

   task automatic reset_on();
      @(posedge clk);
      #2;
      Reset = 1'b1;
      foreach (imem[i]) imem[i] = 16'h5000;
      foreach (wr_mem[i]) wr_mem[i] = 16'hDEAD;
      wr_count = 0;
   endtask

   task automatic reset_release(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
         check("rst_state", State, 0);
         check("rst_pc", PC_Out, 0);
         check("rst_ireq", imem_req, 0);
         check("rst_dreq", dmem_req, 0);
         check("rst_halted", halted, 0);
      end
      Reset = 1'b0;
   endtask

   task automatic run_until_halt(input int budget);
      bit done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(posedge clk);
         #2;
         if (halted) done = 1'b1;
      end
      if (!done) check("halt_timeout", 0, 1);
   endtask

   function automatic logic [15:0] gen_ins();
      int op = int'($urandom_range(0, 15));
      if (op == 5 && $urandom_range(0, 7) != 0) op = 6;
      return {op[3:0], 12'($urandom)};
   endfunction

   initial begin
      imem_ack   = 1'b0;
      dmem_ack   = 1'b0;
      imem_rdata = '0;
      dmem_rdata = '0;
      foreach (dmem[i]) dmem[i] = '0;

      // LDI R1,5; LDI R2,3; ADD R3,R1,R2; STORE R3,0x10; HALT
      reset_on();
      imem[0] = 16'h6051; imem[1] = 16'h6032; imem[2] = 16'h3123; imem[3] = 16'h1310;
      reset_release(3);
      run_until_halt(200);
      repeat (12) @(posedge clk);
      #2;
      check("p1_wr_count", wr_count, 1);
      check("p1_wr_addr", last_wr_addr, 32'h10);
      check("p1_wr_data", last_wr_data, 8);
      check("p1_model_r3", m_regs[3], 8);
      check("p1_state", State, 9);
      check("p1_halted", halted, 1);
      check("p1_pc", PC_Out, 5);

      // Same program with wait-state memories
      reset_on();
      imem[0] = 16'h6051; imem[1] = 16'h6032; imem[2] = 16'h3123; imem[3] = 16'h1310;
      iwait_max = 2;
      dwait_max = 3;
      reset_release(2);
      run_until_halt(300);
      repeat (10) @(posedge clk);
      #2;
      check("p2_wr_count", wr_count, 1);
      check("p2_wr_addr", last_wr_addr, 32'h10);
      check("p2_wr_data", last_wr_data, 8);
      check("p2_pc", PC_Out, 5);
      iwait_max = 0;
      dwait_max = 0;

      // SUB wrap, LOAD, then store both results
      reset_on();
      imem[0] = 16'h6031; imem[1] = 16'h6052; imem[2] = 16'h4124; imem[3] = 16'h2105;
      imem[4] = 16'h1420; imem[5] = 16'h1521;
      dmem[8'h10] = 16'h1234;
      reset_release(2);
      run_until_halt(200);
      check("p3_sub_alu", sub_seen, 16'hFFFE);
      check("p3_r4_store", wr_mem[8'h20], 16'hFFFE);
      check("p3_r5_store", wr_mem[8'h21], 16'h1234);
      check("p3_model_r5", m_regs[5], 16'h1234);

      // BRZ taken on R0, not taken on R1=3
      reset_on();
      imem[0] = 16'h6031; imem[1] = 16'h7020; imem[8'h20] = 16'h7105;
      reset_release(2);
      run_until_halt(200);
      check("brz_nfetch", fa_q.size(), 4);
      if (fa_q.size() == 4) begin
         check("brz_taken", fa_q[2], 32'h20);
         check("brz_not_taken", fa_q[3], 32'h21);
      end
      check("brz_pc", PC_Out, 7'h22);

      // PC wrap from 127 to 0
      reset_on();
      imem[0] = 16'h767F; imem[127] = 16'h6016;
      reset_release(2);
      run_until_halt(200);
      check("wrap_nfetch", fa_q.size(), 4);
      if (fa_q.size() == 4) begin
         check("wrap_from", fa_q[1], 32'h7F);
         check("wrap_to", fa_q[2], 0);
      end
      check("wrap_pc", PC_Out, 2);

      // Asynchronous reset in the middle of a stalled LOAD
      reset_on();
      imem[0] = 16'h6775; imem[1] = 16'h2105;
      dwait_max = 1000;
      reset_release(2);
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk);
            #2;
            if (State == 4'd4) seen = 1'b1;
         end
         check("reach_load_a", State, 4);
      end
      repeat (3) @(posedge clk);
      #3;
      Reset = 1'b1;
      #1;
      check("async_dreq", dmem_req, 0);
      check("async_state", State, 0);
      check("async_ireq", imem_req, 0);
      dwait_max = 0;
      foreach (imem[i]) imem[i] = 16'h5000;
      foreach (wr_mem[i]) wr_mem[i] = 16'hDEAD;
      wr_count = 0;
      imem[0] = 16'h1531;
      reset_release(2);
      run_until_halt(100);
      check("post_rst_r5", wr_mem[8'h31], 0);
      check("post_rst_wr", wr_count, 1);

      // Randomized programs with random wait states
      for (int r = 0; r < 6; r++) begin
         reset_on();
         for (int i = 0; i < 2**PC_W; i++) imem[i] = gen_ins();
         foreach (dmem[i]) dmem[i] = DW'($urandom);
         rand_waits = 1'b1;
         iwait_max  = int'($urandom_range(0, 3));
         dwait_max  = int'($urandom_range(0, 3));
         reset_release(1);
         repeat (400) @(posedge clk);
      end
      rand_waits = 1'b0;
      reset_on();
      repeat (2) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_processor.md
Name: multicycle_processor

Overview:
- Parametrised next-generation multi-cycle 16-bit-instruction processor: FSM control unit, 16-entry register file and ALU in one core.
- Instruction and data memories are external and accessed through req/ack handshakes, so wait-state memories are supported.
- Adds LDI and BRZ to the base NOOP/STORE/LOAD/ADD/SUB/HALT set, and exposes the debug outputs used by the processor testbenches.

Parameters:
- DW, 16, data/register/ALU width (8..32)
- PC_W, 7, program counter and instruction address width (1..8)

Ports:
- clk  in  1  processor clock, rising edge
- Reset  in  1  asynchronous, active-high system reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (= PC)
- imem_rdata  in  16  fetched instruction
- imem_ack  in  1  fetch data valid
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  8  data address
- dmem_wdata  out  DW  store data
- dmem_rdata  in  DW  load data
- dmem_ack  in  1  access complete
- halted  out  1  high while in HALT
- IR_Out  out  16  instruction register
- PC_Out  out  PC_W  program counter
- State  out  4  current FSM state
- NextState  out  4  combinational next state
- ALU_A  out  DW  ALU A input (R[IR[11:8]])
- ALU_B  out  DW  ALU B input (R[IR[7:4]])
- ALU_Out  out  DW  ALU result

Behaviour:
- Encoding is op = IR[15:12]:
  - NOOP = 0
  - STORE = 1: Ra = [11:8], addr = [7:0]
  - LOAD = 2: addr = [11:4], Rd = [3:0]
  - ADD = 3 / SUB = 4: Ra = [11:8], Rb = [7:4], Rd = [3:0]
  - HALT = 5
  - LDI = 6: imm8 = [11:4] zero-extended, Rd = [3:0]
  - BRZ = 7: Ra = [11:8], target = IR[PC_W-1:0]
  - ops 8-15 execute as NOOP.
- States and encodings: INIT 0, FETCH 1, DECODE 2, NOOP 3, LOAD_A 4, LOAD_B 5, STORE 6, ADD 7, SUB 8, HALT 9, LDI 10, BRZ 11.
- Reset (asynchronous):
  - State = INIT, PC = 0, IR = 0, load-data register = 0, all registers = 0.
  - imem_req, dmem_req, dmem_we and halted are decoded from State, so they drop immediately, mid-transaction included.
- INIT -> FETCH.
- FETCH:
  - imem_req = 1, imem_addr = PC.
  - On imem_ack: IR <= imem_rdata, PC <= PC+1 modulo 2^PC_W (2^PC_W-1 wraps to 0), then -> DECODE.
  - Otherwise stay in FETCH.
- DECODE: dispatch on op.
- NOOP -> FETCH.
- LOAD_A:
  - dmem_req = 1, dmem_we = 0.
  - On dmem_ack: capture dmem_rdata, then -> LOAD_B.
- LOAD_B: R[Rd] <= captured data, then -> FETCH.
- STORE:
  - dmem_req = 1, dmem_we = 1, dmem_wdata = R[Ra].
  - Hold until dmem_ack, then -> FETCH.
- ADD / SUB: R[Rd] <= A ± B, truncated to DW (wraps, no flags), then -> FETCH.
- LDI: R[Rd] <= imm8 (truncated if DW < 8, n/a in range), then -> FETCH.
- BRZ: if R[Ra] == 0 then PC <= target; else PC unchanged. Then -> FETCH.
- HALT:
  - halted = 1; remain in HALT until Reset.
  - No memory requests are issued while halted.
- Handshake rules:
  - Address, we and wdata are stable while req is high.
  - ack is ignored when req is low.
  - Same-cycle ack (zero wait) is legal.
  - Unbounded wait is legal (no timeout).
- Latency with zero-wait memories:
  - NOOP, ADD, SUB, LDI, BRZ, STORE: 3 cycles.
  - LOAD: 4 cycles.
- dmem_addr = IR[7:0] in STORE and IR[11:4] in LOAD_A; it is don't-care elsewhere and driven 0.
- ALU_Out:
  - ADD state: A+B.
  - SUB state: A-B.
  - STORE and BRZ states: A.
  - All other states: 0.
- Register file:
  - Reads are combinational.
  - Rd = 0 is an ordinary register (writable).
  - A register written in cycle n is readable in cycle n+1.

Decomposition:
- Package proc_pkg holds:
  - opcode_t enum (4-bit)
  - state_t enum (4-bit, encodings above)
  - alu_op_t enum (ADD, SUB, PASS_A, ZERO)
  - field-slice constants
- One sub-module, proc_regfile:
  - 16 x DW registers, two combinational read ports, one write port.
  - Asynchronous reset via Reset.
- FSM, PC, IR and ALU stay in multicycle_processor.

Test Plan:
- Reset for 3 cycles with zero-wait memories -> during reset State=0, PC_Out=0, imem_req=0, dmem_req=0, halted=0; first fetch address is 0.
- Program `LDI R1,5; LDI R2,3; ADD R3,R1,R2; STORE R3,0x10; HALT` -> one dmem write with addr 0x10, data 8; then State=9, halted=1, PC_Out=5, held for 10+ cycles with no requests.
- Same program with imem_ack delayed 2 cycles per fetch and dmem_ack delayed 3 cycles -> FETCH held 3 cycles each, imem_addr stable; same final memory write and register contents.
- `LDI R1,3; LDI R2,5; SUB R4,R1,R2` -> ALU_Out=0xFFFE and R4=0xFFFE at DW=16; with DW=8 -> 0xFE. Then `LOAD R5,0x10` with memory returning 0x1234 -> R5=0x1234 after LOAD_B.
- BRZ on R0=0 with target 0x20 -> next imem_addr=0x20. BRZ on R1=3 -> not taken, PC increments. Separately, fetch at PC=127 (PC_W=7) -> next PC 0.
- Assert Reset while in LOAD_A with dmem_ack low -> dmem_req drops and State=0 without waiting for a clock edge. After release, fetch restarts at address 0 and all registers read 0.
